pipe_skid_buf: RTL and testbench
================================

# pipe_skid_buf

Two-entry valid/ready skid buffer that decouples an upstream producer from a downstream consumer with full throughput and no combinational path from `out_ready` to `in_ready`. It is the flow-controlled counterpart of the plain enable-flop pipeline stage: that stage only captures when told to, while this block decides when capture is allowed and absorbs one beat of backpressure. It is used to break timing on long valid/ready paths between pipeline stages.

## Interface
- `WIDTH`, 64, payload width in bits.
- `CNT_W`, 32, stall counter width (used only with `PIPE_SKID_BUF_STALL_CNT_EN`).

- `clk`  input  1  single clock, all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_valid`  input  1  upstream beat present.
- `in_data`  input  WIDTH  upstream payload.
- `in_ready`  output  1  buffer can accept; decoded only from the state register.
- `out_valid`  output  1  downstream beat present.
- `out_data`  output  WIDTH  downstream payload, driven from the main data register.
- `out_ready`  input  1  downstream accepts.
- `stall_cnt`  output  CNT_W  backpressure cycle count; present only with `PIPE_SKID_BUF_STALL_CNT_EN`.

## Operation
- `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- Storage: main register (`main_q`, drives `out_data`), skid register (`skid_q`). Data registers have no reset.
- State machine with states EMPTY, ONE and FULL:
  - EMPTY: `out_valid`=0, `in_ready`=1. On `in_fire`, `main_q`<=`in_data` and the state goes to ONE.
  - ONE: `out_valid`=1, `in_ready`=1.
    - `in_fire & out_fire`: `main_q`<=`in_data`, stay in ONE.
    - `in_fire & !out_fire`: `skid_q`<=`in_data`, go to FULL.
    - `!in_fire & out_fire`: go to EMPTY.
    - Otherwise hold.
  - FULL: `out_valid`=1, `in_ready`=0, so `in_valid` is ignored. On `out_fire`, `main_q`<=`skid_q` and the state goes to ONE. Otherwise hold.
- Ordering: strictly FIFO. The skid entry is always older than any new input.
- Upstream rules:
  - `in_data` must stay stable while `in_valid=1` and `in_ready=0`.
  - `in_valid` is not dropped before acceptance. The buffer does not check this.
- Downstream guarantee: while `out_valid=1` and `out_ready=0`, `out_data` and `out_valid` do not change.
- Reset:
  - State goes to EMPTY. `out_valid`=0, `in_ready`=1 and `stall_cnt`=0 from the first cycle after `rst` is sampled high.
  - `out_data` is don't-care while `out_valid=0`.
  - Reset during FULL or ONE discards buffered beats without any output.
  - `in_valid` during reset is ignored.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle while `out_ready=1`.
- `in_ready` falls one cycle after the first stalled accept in ONE. At most one extra beat is absorbed.
- `in_ready` rises the cycle after `out_fire` in FULL.
- No combinational path from `out_ready` or `in_valid` to `in_ready`. `out_valid` and `out_data` come only from registers.

## Configuration
- `PIPE_SKID_BUF_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments by 1 each cycle with `out_valid & !out_ready`.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - Synchronous reset clears it to 0.
- Not defined: the port and counter are absent, and the rest of the behaviour is unchanged.

## Structure
- Shared package `pipe_skid_pkg`:
  - `typedef enum logic [1:0] {SKID_EMPTY=2'd0, SKID_ONE=2'd1, SKID_FULL=2'd2} skid_state_t`.
  - Encoding 2'd3 is illegal; the FSM recovers to SKID_EMPTY.
- Sub-module: instantiate the codebase's `flop_en` twice, once for `main_q` and once for `skid_q`, with enables derived from the FSM. The FSM and counter stay inline.

## Test plan
- Stream with `out_ready`=1: drive 0x1,0x2,0x3 on consecutive cycles → outputs 0x1,0x2,0x3 one cycle later each, `in_ready` stays 1, `stall_cnt`=0.
- Backpressure:
  - Stimulus: send 0xA then 0xB with `out_ready`=0, then present 0xC.
  - Required: `in_ready`=0 after 0xB is accepted, 0xC is held off, `out_data`=0xA stays stable.
  - Release: set `out_ready`=1 → 0xA,0xB,0xC in order, and `in_ready` returns to 1 one cycle after 0xA leaves.
- Simultaneous fire in ONE: with 0x5 held, present 0x6 and set `out_ready`=1 in the same cycle → next cycle `out_data`=0x6, state stays ONE, `in_ready`=1.
- Reset mid-FULL: fill the buffer with 0x11,0x22, assert `rst` for 1 cycle → `out_valid`=0, `in_ready`=1, and neither 0x11 nor 0x22 ever appears.
- Stall counter (macro on): hold `out_valid=1`, `out_ready=0` for 7 cycles → `stall_cnt`=7. With CNT_W=3, hold for 10 cycles → `stall_cnt` stays at 7.
- Random: random `in_valid`/`out_ready` for 10k cycles → scoreboard shows no loss, no duplication, and in-order delivery.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// Shared types for the pipe_skid_buf two-entry valid/ready skid buffer.
package pipe_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf_flop_en.sv
// flop_en: plain enable-gated data register with no reset, used for the
// skid buffer's main and skid storage.
module flop_en #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready skid buffer, registered in_ready.
// Optional backpressure counter enabled by `define PIPE_SKID_BUF_STALL_CNT_EN.
module pipe_skid_buf
    import pipe_skid_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t      r_state;
    skid_state_t      w_stateNext;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_mainEn;
    logic             w_skidEn;
    logic [WIDTH-1:0] w_mainD;
    logic [WIDTH-1:0] w_mainQ;
    logic [WIDTH-1:0] w_skidQ;

    // Handshake outputs decode only the state register; encoding 3 reads as not ready/not valid.
    assign in_ready  = (r_state == SKID_EMPTY) || (r_state == SKID_ONE);
    assign out_valid = (r_state == SKID_ONE) || (r_state == SKID_FULL);
    assign w_inFire  = in_valid & in_ready;
    assign w_outFire = out_valid & out_ready;

    assign w_mainEn = ((r_state == SKID_EMPTY) & w_inFire)
                    | ((r_state == SKID_ONE) & w_inFire & w_outFire)
                    | ((r_state == SKID_FULL) & w_outFire);
    assign w_skidEn = (r_state == SKID_ONE) & w_inFire & ~w_outFire;
    assign w_mainD  = (r_state == SKID_FULL) ? w_skidQ : in_data;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            SKID_EMPTY: begin
                if (w_inFire) begin
                    w_stateNext = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_inFire && !w_outFire) begin
                    w_stateNext = SKID_FULL;
                end else if (!w_inFire && w_outFire) begin
                    w_stateNext = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_outFire) begin
                    w_stateNext = SKID_ONE;
                end
            end
            default: w_stateNext = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    flop_en #(.WIDTH(WIDTH)) u_mainReg (
        .clk  (clk),
        .i_en (w_mainEn),
        .i_d  (w_mainD),
        .o_q  (w_mainQ)
    );

    flop_en #(.WIDTH(WIDTH)) u_skidReg (
        .clk  (clk),
        .i_en (w_skidEn),
        .i_d  (in_data),
        .o_q  (w_skidQ)
    );

    assign out_data = w_mainQ;

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;

    // Saturating count of cycles where a beat waits on the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed and randomised self-checking bench for pipe_skid_buf.
// Stall counter tests are built when PIPE_SKID_BUF_STALL_CNT_EN is defined.
module tb_pipe_skid_buf;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    int               checks = 0;
    int               failures = 0;

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    logic [31:0]      stall_cnt;
    logic             small_in_ready;
    logic             small_out_valid;
    logic [WIDTH-1:0] small_out_data;
    logic [2:0]       small_stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(3)) dutSmall (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (small_in_ready),
        .out_valid (small_out_valid),
        .out_data  (small_out_data),
        .out_ready (out_ready),
        .stall_cnt (small_stall_cnt)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
        step();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
        end
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
        end
`endif
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ignored_in got=%b want=0", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(i) || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_%0d got v=%b d=%h r=%b want v=1 d=%h r=1",
                         i, out_valid, out_data, in_ready, 64'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stream_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hA || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_first got v=%b d=%h r=%b want v=1 d=a r=1", out_valid, out_data, in_ready);
        end
        in_data = 64'hB;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 64'hA) begin
            failures++;
            $display("[TB] FAIL bp_full got r=%b d=%h want r=0 d=a", in_ready, out_data);
        end
        in_data = 64'hC;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'hA) begin
                failures++;
                $display("[TB] FAIL bp_hold got r=%b v=%b d=%h want r=0 v=1 d=a", in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_data !== 64'hB || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release_b got d=%h r=%b v=%b want d=b r=1 v=1", out_data, in_ready, out_valid);
        end
        step();
        checks++;
        if (out_data !== 64'hC || out_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_release_c got d=%h v=%b want d=c v=1", out_data, out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_empty got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h5;
        step();
        in_data = 64'h6; out_ready = 1'b1;
        step();
        checks++;
        if (out_data !== 64'h6 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL simul_fire got d=%h v=%b r=%b want d=6 v=1 r=1", out_data, out_valid, in_ready);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL simul_drain got v=%b want 0 (state was not ONE)", out_valid);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11;
        step();
        in_data = 64'h22;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL rstfull_fill got r=%b want 0", in_ready);
        end
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL rstfull_reset got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("[TB] FAIL rstfull_leak got v=%b d=%h want v=0", out_valid, out_data);
            end
        end
    endtask

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h77;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (stall_cnt !== 32'd7) begin
            failures++; $display("[TB] FAIL stall_cnt_7 got=%0d want=7", stall_cnt);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (stall_cnt !== 32'd10) begin
            failures++; $display("[TB] FAIL stall_cnt_10 got=%0d want=10", stall_cnt);
        end
        checks++;
        if (small_stall_cnt !== 3'd7) begin
            failures++; $display("[TB] FAIL stall_cnt_sat got=%0d want=7", small_stall_cnt);
        end
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (stall_cnt !== 32'd10 || out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_cnt_idle got=%0d v=%b want=10 v=0", stall_cnt, out_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] expQ[$];
        logic [WIDTH-1:0] nextData;
        logic             inFire;
        logic             outFire;
        nextData = 64'h1000;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1; in_data = nextData; nextData++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            inFire  = in_valid & in_ready;
            outFire = out_valid & out_ready;
            if (outFire) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++; $display("[TB] FAIL rand_dup got d=%h want no beat", out_data);
                end else begin
                    if (out_data !== expQ[0]) begin
                        failures++; $display("[TB] FAIL rand_order got=%h want=%h", out_data, expQ[0]);
                    end
                    void'(expQ.pop_front());
                end
            end
            step();
            if (inFire) begin
                expQ.push_back(in_data);
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4 && out_valid; i++) begin
            checks++;
            if (expQ.size() == 0 || out_data !== expQ[0]) begin
                failures++; $display("[TB] FAIL rand_drain got=%h", out_data);
            end
            if (expQ.size() != 0) void'(expQ.pop_front());
            step();
        end
        checks++;
        if (expQ.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL rand_loss got left=%0d v=%b want left=0 v=0", expQ.size(), out_valid);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_reset_full();
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
